// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and 7-segment patterns for the sequenced ALU
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 8'hC0;
      4'd1:    seg_digit = 8'hF9;
      4'd2:    seg_digit = 8'hA4;
      4'd3:    seg_digit = 8'hB0;
      4'd4:    seg_digit = 8'h99;
      4'd5:    seg_digit = 8'h92;
      4'd6:    seg_digit = 8'h82;
      4'd7:    seg_digit = 8'hF8;
      4'd8:    seg_digit = 8'h80;
      4'd9:    seg_digit = 8'h90;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_top_seg_scan.sv
// rtl/alu_seq_top_seg_scan.sv - multiplexed 7-segment scanner with blank and dash masks
module seg_scan
  import alu_seq_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dash,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     anodes
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [7:0]    pat;

  // Dash wins over blank so a negative sign is never suppressed
  always_comb begin
    pat = seg_digit(digits[4*idx +: 4]);
    if (blank[idx]) pat = SEG_BLANK;
    if (dash[idx])  pat = SEG_DASH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      seg    <= SEG_BLANK;
      anodes <= '1;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt    <= '0;
      seg    <= pat;
      anodes <= ~(DIGITS'(1) << idx);
      idx    <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_top.sv
// rtl/alu_seq_top.sv - start/busy/done ALU with shift-add multiply, double-dabble BCD and display
module alu_seq_top
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  D,
  input  logic              En_A,
  input  logic              En_B,
  input  logic [2:0]        ctrl,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              carry,
  output logic              zero,
  output logic              neg,
  output logic              ovf,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] anodes
);
  localparam int RW    = 2 * WIDTH;
  localparam int BCD_D = (RW * 31) / 100 + 1;
  localparam int CW    = $clog2(RW);
  localparam int SW    = $clog2(WIDTH) + 1;

  state_t              state, state_n;
  logic [WIDTH-1:0]    reg_a, reg_b, op_b;
  logic [RW-1:0]       op_a, res, bin, alu;
  logic [2:0]          op_code;
  logic [CW-1:0]       cnt;
  logic                res_carry, res_neg, alu_c, alu_n, ovf_c, lead;
  logic [4*BCD_D-1:0]  bcd, dab, dab_next;
  logic [4*DIGITS-1:0] disp;
  logic [DIGITS-1:0]   blank, dash;

  // MUL reuses this path one partial product per cycle: res accumulates, op_a/op_b shift
  always_comb begin
    alu   = '0;
    alu_c = 1'b0;
    alu_n = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu   = op_a + RW'(op_b);
        alu_c = alu[WIDTH];
      end
      OP_SUB: begin
        if (op_a < RW'(op_b)) begin
          alu   = RW'(op_b) - op_a;
          alu_c = 1'b1;
          alu_n = 1'b1;
        end else begin
          alu = op_a - RW'(op_b);
        end
      end
      OP_AND:  alu = op_a & RW'(op_b);
      OP_OR:   alu = op_a | RW'(op_b);
      OP_XOR:  alu = op_a ^ RW'(op_b);
      OP_SHL:  alu = op_a << op_b[SW-1:0];
      OP_MUL:  alu = res + (op_b[0] ? op_a : '0);
      default: alu = op_a;
    endcase
  end

  always_comb begin
    dab = bcd;
    for (int i = 0; i < BCD_D; i++)
      if (dab[4*i +: 4] >= 4'd5) dab[4*i +: 4] = dab[4*i +: 4] + 4'd3;
    dab_next = (dab << 1) | (4*BCD_D)'(bin[RW-1]);
    ovf_c = 1'b0;
    for (int i = 0; i < BCD_D; i++)
      if (dab_next[4*i +: 4] != 4'd0 && (i >= DIGITS || (res_neg && i >= DIGITS - 1)))
        ovf_c = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_EXEC;
      S_EXEC: if (op_code != OP_MUL || cnt == CW'(WIDTH - 1)) state_n = S_CONV;
      S_CONV: if (cnt == CW'(RW - 1)) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_EXEC) || (state == S_CONV);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a     <= '0;
      reg_b     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= OP_ADD;
      res       <= '0;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      res_carry <= 1'b0;
      res_neg   <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      disp      <= '0;
    end else begin
      if (En_A) reg_a <= D;
      if (En_B) reg_b <= D;
      case (state)
        S_IDLE: if (start) begin
          op_a    <= RW'(reg_a);
          op_b    <= reg_b;
          op_code <= ctrl;
          res     <= '0;
          cnt     <= '0;
        end
        S_EXEC: begin
          res       <= alu;
          res_carry <= alu_c;
          res_neg   <= alu_n;
          op_a      <= op_a << 1;
          op_b      <= op_b >> 1;
          cnt       <= cnt + 1'b1;
          if (state_n == S_CONV) begin
            bin <= alu;
            bcd <= '0;
            cnt <= '0;
          end
        end
        S_CONV: begin
          bcd <= dab_next;
          bin <= bin << 1;
          cnt <= cnt + 1'b1;
          if (state_n == S_DONE) begin
            carry <= res_carry;
            zero  <= (res == '0);
            neg   <= res_neg;
            ovf   <= ovf_c;
            disp  <= (4*DIGITS)'(dab_next);
          end
        end
        default: ;
      endcase
    end
  end

  // Blank leading zeros from the left; the units digit is always shown
  always_comb begin
    blank = '0;
    dash  = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (disp[4*i +: 4] != 4'd0) lead = 1'b0;
      blank[i] = lead;
    end
    if (neg) dash[DIGITS-1] = 1'b1;
    if (ovf) dash = '1;
  end

  seg_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .digits (disp),
    .blank  (blank),
    .dash   (dash),
    .seg    (seg),
    .anodes (anodes)
  );

endmodule

// File: tb/tb_alu_seq_top.sv
// tb/tb_alu_seq_top.sv - directed table, random model comparison and corner sequences for alu_seq_top
module tb_alu_seq_top;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam logic [7:0] SEGTAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [3:0]  fl;
    logic [31:0] disp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  D;
  logic        En_A, En_B, start;
  logic [2:0]  ctrl;
  logic        busy, done, carry, zero, neg, ovf;
  logic [7:0]  seg;
  logic [3:0]  anodes;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  alu_seq_top #(.WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .D(D), .En_A(En_A), .En_B(En_B), .ctrl(ctrl), .start(start),
    .busy(busy), .done(done), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf),
    .seg(seg), .anodes(anodes)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input int a, input int b, input int op,
                                output int r, output logic [3:0] fl);
    logic c, n, o;
    c = 1'b0;
    n = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: if (a < b) begin r = b - a; n = 1'b1; c = 1'b1; end else r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % 16)) % 65536;
      6: r = a * b;
      default: r = a;
    endcase
    o  = n ? (r >= 1000) : (r >= 10000);
    fl = {c, (r == 0), n, o};
  endfunction

  function automatic logic [31:0] exp_disp(input int r, input logic n, input logic o);
    logic [31:0] e;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (o || (n && i == DIGITS - 1)) e[8*i +: 8] = 8'hBF;
      else if (i > 0 && r < p)         e[8*i +: 8] = 8'hFF;
      else                             e[8*i +: 8] = SEGTAB[(r / p) % 10];
      p = p * 10;
    end
    return e;
  endfunction

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    D = a; En_A = 1'b1;
    @(negedge clk);
    En_A = 1'b0; D = b; En_B = 1'b1;
    @(negedge clk);
    En_B = 1'b0;
  endtask

  task automatic read_display(input string tag, output logic [31:0] disp);
    logic [3:0] seen;
    seen = 4'h0;
    disp = '1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      for (int i = 0; i < DIGITS; i++)
        if (anodes == ~(4'b0001 << i)) begin
          disp[8*i +: 8] = seg;
          seen[i] = 1'b1;
        end
    end
    chk({tag, "_scan_cover"}, 32'(seen), 32'hF);
  endtask

  task automatic start_op(input logic [2:0] op, input int poke_at, input logic [7:0] poke_d,
                          output int lat, output logic [3:0] fl);
    ctrl = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ctrl = ~op;
    lat = -1;
    fl  = 4'h0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 1) chk("busy_after_start", 32'(busy), 32'd1);
      if (done === 1'b1) begin
        lat = n;
        fl  = {carry, zero, neg, ovf};
        chk("busy_at_done", 32'(busy), 32'd0);
        break;
      end
      start = (n == poke_at);
      En_A  = (n == poke_at);
      if (n == poke_at) D = poke_d;
      @(negedge clk);
    end
    start = 1'b0;
    En_A  = 1'b0;
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done within 60 cycles, expected one");
    end
  endtask

  task automatic run_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic [3:0] efl,
                           input logic [31:0] edisp, input int elat);
    int lat;
    logic [3:0]  fl;
    logic [31:0] d;
    load(a, b);
    start_op(op, 0, 8'd0, lat, fl);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_flags_czno"}, 32'(fl), 32'(efl));
    read_display(tag, d);
    chk({tag, "_display"}, d, edisp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tab [18];
    logic [31:0] d;
    logic [3:0]  fl;
    int          lat, r, a, b, op, dc;

    tab[0]  = '{8'd200, 8'd100, 3'd0, 4'b1000, 32'hFFB0C0C0, 18};
    tab[1]  = '{8'd5,   8'd9,   3'd1, 4'b1010, 32'hBFFFFF99, 18};
    tab[2]  = '{8'd9,   8'd9,   3'd1, 4'b0100, 32'hFFFFFFC0, 18};
    tab[3]  = '{8'd255, 8'd255, 3'd6, 4'b0001, 32'hBFBFBFBF, 25};
    tab[4]  = '{8'd99,  8'd99,  3'd6, 4'b0000, 32'h9080C0F9, 25};
    tab[5]  = '{8'h0F,  8'h3C,  3'd2, 4'b0000, 32'hFFFFF9A4, 18};
    tab[6]  = '{8'd3,   8'd4,   3'd5, 4'b0000, 32'hFFFF9980, 18};
    tab[7]  = '{8'd255, 8'd255, 3'd0, 4'b1000, 32'hFF92F9C0, 18};
    tab[8]  = '{8'd0,   8'd77,  3'd7, 4'b0100, 32'hFFFFFFC0, 18};
    tab[9]  = '{8'd0,   8'd200, 3'd1, 4'b1010, 32'hBFA4C0C0, 18};
    tab[10] = '{8'hF0,  8'hFF,  3'd4, 4'b0000, 32'hFFFFF992, 18};
    tab[11] = '{8'h80,  8'h01,  3'd3, 4'b0000, 32'hFFF9A490, 18};
    tab[12] = '{8'd0,   8'd77,  3'd6, 4'b0100, 32'hFFFFFFC0, 25};
    tab[13] = '{8'd1,   8'd15,  3'd5, 4'b0001, 32'hBFBFBFBF, 18};
    tab[14] = '{8'd10,  8'd16,  3'd5, 4'b0000, 32'hFFFFF9C0, 18};
    tab[15] = '{8'd99,  8'd101, 3'd6, 4'b0000, 32'h90909090, 25};
    tab[16] = '{8'd100, 8'd100, 3'd6, 4'b0001, 32'hBFBFBFBF, 25};
    tab[17] = '{8'd7,   8'd0,   3'd7, 4'b0000, 32'hFFFFFFF8, 18};

    rst = 1'b1; D = '0; En_A = 1'b0; En_B = 1'b0; ctrl = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_seg", 32'(seg), 32'hFF);
    chk("reset_anodes", 32'(anodes), 32'hF);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_flags_czno", 32'({carry, zero, neg, ovf}), 32'b0100);
    rst = 1'b0;
    read_display("reset", d);
    chk("reset_display", d, 32'hFFFFFFC0);

    for (int i = 0; i < 18; i++)
      run_check($sformatf("vec%0d", i), tab[i].a, tab[i].b, tab[i].op,
                tab[i].fl, tab[i].disp, tab[i].lat);

    // Start and A-load while a multiply is in flight
    load(8'd12, 8'd10);
    start_op(3'd6, 5, 8'd7, lat, fl);
    chk("midmul_latency", 32'(lat), 32'd25);
    chk("midmul_flags_czno", 32'(fl), 32'b0000);
    @(negedge clk); #1;
    dc = done_cnt;
    read_display("midmul", d);
    chk("midmul_display", d, 32'hFFF9A4C0);
    chk("midmul_no_second_done", 32'(done_cnt), 32'(dc));
    D = 8'd10; En_B = 1'b1;
    @(negedge clk);
    En_B = 1'b0;
    start_op(3'd0, 0, 8'd0, lat, fl);
    chk("after_poke_latency", 32'(lat), 32'd18);
    chk("after_poke_flags_czno", 32'(fl), 32'b0000);
    read_display("after_poke", d);
    chk("after_poke_display", d, 32'hFFFFF9F8);

    for (int i = 0; i < 20; i++) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 7));
      model(a, b, op, r, fl);
      run_check($sformatf("rnd%0d_op%0d", i, op), 8'(a), 8'(b), 3'(op), fl,
                exp_disp(r, fl[1], fl[0]), (op == 6) ? 25 : 18);
    end

    // Reset in the middle of conversion
    run_check("prereset", 8'd5, 8'd9, 3'd1, 4'b1010, 32'hBFFFFF99, 18);
    load(8'd200, 8'd100);
    ctrl = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midconv_busy", 32'(busy), 32'd1);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    chk("midconv_rst_busy", 32'(busy), 32'd0);
    chk("midconv_rst_done", 32'(done), 32'd0);
    chk("midconv_rst_flags_czno", 32'({carry, zero, neg, ovf}), 32'b0100);
    chk("midconv_rst_seg", 32'(seg), 32'hFF);
    chk("midconv_rst_anodes", 32'(anodes), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("midconv_no_done", 32'(done_cnt), 32'(dc));
    read_display("midconv", d);
    chk("midconv_display", d, 32'hFFFFFFC0);
    chk("midconv_flags_after", 32'({carry, zero, neg, ovf}), 32'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
